// File: rtl/bsg_aes_input_packer.sv
// Packs a narrow word stream into one {plaintext, key} AES-256 request.
// Key-reuse mode lets plaintext-only requests pair with the previously stored key.
module bsg_aes_input_packer #(
    parameter int unsigned word_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [word_width_p-1:0] data_i,
    input  logic                    v_i,
    input  logic                    reuse_key_i,
    output logic                    ready_o,
    output logic [383:0]            data_o,
    output logic                    v_o,
    input  logic                    ready_i,
    output logic                    key_loaded_o
);

    localparam int unsigned pt_words_lp  = 128 / word_width_p;
    localparam int unsigned key_words_lp = 256 / word_width_p;
    localparam int unsigned cnt_width_lp = $clog2(key_words_lp);

    typedef enum logic [1:0] {
        collect_pt_s  = 2'd0,
        collect_key_s = 2'd1,
        full_s        = 2'd2
    } state_e;

    state_e                                    state_r;
    state_e                                    state_n;
    logic [cnt_width_lp-1:0]                   cnt_r;
    logic                                      reuse_r;
    logic                                      key_loaded_r;
    logic [pt_words_lp-1:0][word_width_p-1:0]  pt_r;
    logic [key_words_lp-1:0][word_width_p-1:0] key_r;

    logic accept;
    logic cnt_first;
    logic pt_last;
    logic key_last;
    logic reuse_now;
    logic reuse_eff;
    logic pt_wr;
    logic key_wr;

    assign accept    = v_i & ready_o;
    assign cnt_first = (cnt_r == '0);
    assign pt_last   = (cnt_r == cnt_width_lp'(pt_words_lp - 1));
    assign key_last  = (cnt_r == cnt_width_lp'(key_words_lp - 1));
    assign reuse_now = reuse_key_i & key_loaded_r;
    // The latched flag is not visible yet when the first word is also the last one.
    assign reuse_eff = cnt_first ? reuse_now : reuse_r;
    assign pt_wr     = accept & (state_r == collect_pt_s);
    assign key_wr    = accept & (state_r == collect_key_s);

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= collect_pt_s;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            collect_pt_s: begin
                if (accept && pt_last) begin
                    state_n = reuse_eff ? full_s : collect_key_s;
                end
            end
            collect_key_s: begin
                if (accept && key_last) begin
                    state_n = full_s;
                end
            end
            full_s: begin
                if (ready_i) begin
                    state_n = collect_pt_s;
                end
            end
            default: state_n = collect_pt_s;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        ready_o = 1'b1;
        v_o     = 1'b0;
        case (state_r)
            full_s: begin
                ready_o = 1'b0;
                v_o     = 1'b1;
            end
            default: begin
                ready_o = 1'b1;
                v_o     = 1'b0;
            end
        endcase
    end

    // Word counter, reuse flag and key-loaded flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_r        <= '0;
            reuse_r      <= 1'b0;
            key_loaded_r <= 1'b0;
        end else begin
            if (pt_wr) begin
                cnt_r <= pt_last ? '0 : cnt_r + cnt_width_lp'(1);
                if (cnt_first) begin
                    reuse_r <= reuse_now;
                end
            end else if (key_wr) begin
                cnt_r <= key_last ? '0 : cnt_r + cnt_width_lp'(1);
                if (key_last) begin
                    key_loaded_r <= 1'b1;
                end
            end
        end
    end

    // Plaintext slots: slot 0 holds the most-significant word
    for (genvar i = 0; i < int'(pt_words_lp); i++) begin : g_pt
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                pt_r[pt_words_lp-1-i] <= '0;
            end else if (pt_wr && (cnt_r == cnt_width_lp'(i))) begin
                pt_r[pt_words_lp-1-i] <= data_i;
            end
        end
    end

    // Key slots are overwritten in place as each key word arrives
    for (genvar i = 0; i < int'(key_words_lp); i++) begin : g_key
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                key_r[key_words_lp-1-i] <= '0;
            end else if (key_wr && (cnt_r == cnt_width_lp'(i))) begin
                key_r[key_words_lp-1-i] <= data_i;
            end
        end
    end

    assign data_o       = {pt_r, key_r};
    assign key_loaded_o = key_loaded_r;

endmodule

// File: doc/bsg_aes_input_packer.md
Name: bsg_aes_input_packer

Overview:
Upstream feeder for the AES-256 encryption wrapper. Collects a narrow word stream from the chip-level link into one 384-bit request. The request is {plaintext[127:0], key[255:0]}. The packed request is presented to the encryptor's 384-bit data_i with a valid/ready handshake. A key-reuse mode lets a stream of plaintext blocks share one previously loaded 256-bit key, so the key is not re-sent for every block.

Parameters:
word_width_p, 32, input word width in bits; must divide 128 (legal values: 8, 16, 32, 64, 128).
pt_words_lp, 128/word_width_p, local parameter: number of plaintext words per request.
key_words_lp, 256/word_width_p, local parameter: number of key words per request.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
reset_i  input  1  asynchronous, active-high reset.
data_i  input  word_width_p  input word.
v_i  input  1  input word valid.
reuse_key_i  input  1  sampled only on the first word of a request; 1 means skip key words and reuse the stored key.
ready_o  output  1  packer can accept a word this cycle.
data_o  output  384  packed request {plaintext, key}; plaintext occupies [383:256].
v_o  output  1  packed request valid.
ready_i  input  1  downstream (encryptor) ready.
key_loaded_o  output  1  a complete key has been stored since reset.

Behaviour:
- Reset: one clock; reset_i is asynchronous and active-high.
- Reset values: state=COLLECT_PT, word counter=0, ready_o=1, v_o=0, key_loaded_o=0, data_o=0 (plaintext and key registers cleared).
- Input handshake: a word is accepted when v_i & ready_o. ready_o does not depend on v_i.
- Output handshake: a request is consumed when v_o & ready_i. data_o is held stable while v_o=1 and not consumed.
- Word order: plaintext words come first, most-significant word first. The first word fills pt[127 -: word_width_p]. Key words follow, also MSW first; the first key word fills key[255 -: word_width_p].
- State machine:
  - COLLECT_PT: ready_o=1.
    - On each accepted word: store it at slot cnt, then cnt++.
    - On the first word (cnt=0): latch reuse_r = reuse_key_i & key_loaded_o. A reuse request when no key is loaded is treated as reuse=0.
    - On accepting word pt_words_lp-1: cnt←0. Go to FULL if reuse_r (or the just-latched value when pt_words_lp=1), else go to COLLECT_KEY.
  - COLLECT_KEY: ready_o=1.
    - Store each accepted word at key slot cnt, then cnt++.
    - On word key_words_lp-1: cnt←0, key_loaded_o←1, go to FULL.
    - Key words overwrite the stored key in place. The old key is not preserved mid-load.
  - FULL: ready_o=0, v_o=1. When ready_i=1: go to COLLECT_PT; v_o drops the next cycle.
- Latency: v_o rises the cycle after the last word of a request is accepted. No combinational path from data_i to data_o.
- Throughput:
  - One word per cycle while collecting.
  - One dead input cycle per request (the FULL cycle), even if ready_i is already high.
  - Full key request: 12+1 cycles. Reuse request: 4+1 cycles (at word_width_p=32).
- Back-pressure: v_i is ignored while ready_o=0. No word is dropped or duplicated.
- Boundaries:
  - Counter wraps only through an explicit clear at the last word; it never exceeds pt_words_lp-1 or key_words_lp-1.
  - reuse_key_i is ignored on every word except the first of a request.
- Reset mid-operation: the partial request is discarded, key_loaded_o←0, and the stored key is cleared. Reset asserted while v_o=1 drops v_o asynchronously.

Test Plan:
- Reset then 12 words 0x00000001..0x0000000C with reuse_key_i=0 → one cycle after word 12, v_o=1. data_o[383:256]=0x00000001_00000002_00000003_00000004, data_o[255:0]=0x00000005_…_0000000C, key_loaded_o=1.
- After the case above, 4 words 0xA0..0xA3 with reuse_key_i=1 on the first → v_o one cycle after word 4. Plaintext=0x000000A0_000000A1_000000A2_000000A3; key equals the previous 0x5..0xC.
- Directly after reset, reuse_key_i=1 with 12 words 0x10..0x1B → treated as a full request: key field=0x14..0x1B and key_loaded_o=1.
- Hold ready_i=0 for 20 cycles with v_o=1 and v_i toggling → ready_o=0 throughout, data_o unchanged, no words absorbed. ready_i=1 for 1 cycle → v_o=0 and ready_o=1 the next cycle.
- Random v_i gaps (50% duty) over 100 requests mixing reuse 0 and 1 → every output matches a scoreboard built from the accepted words; no loss or duplication.
- Assert reset_i after 7 of 12 words, then send a fresh 12-word request 0x20..0x2B → output holds only the new values; key_loaded_o is 0 until the 12th word is accepted.
